// File: rtl/alu_mul_sequencer.sv
// Shift-and-add unsigned multiplier controller that borrows the shared integer ALU
// (ADD only) for WIDTH cycles and returns either word of the 2*WIDTH product.
module alu_mul_sequencer #(
  parameter int unsigned      WIDTH   = 32,
  parameter int unsigned      CNT_W   = $clog2(WIDTH),
  parameter int unsigned      CTR_W   = 4,
  parameter logic [CTR_W-1:0] ALU_ADD = CTR_W'(2),
  parameter logic [CTR_W-1:0] ALU_AND = CTR_W'(0)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             hi_sel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [CTR_W-1:0] alu_ctr,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_out
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t           state_q,  state_d;
  logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
  logic [WIDTH-1:0] mcand_q,  mcand_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic             hi_sel_q, hi_sel_d;
  logic [WIDTH-1:0] result_q, result_d;

  logic             carry;
  logic [WIDTH-1:0] next_hi;
  logic [WIDTH-1:0] next_lo;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      mcand_q  <= '0;
      cnt_q    <= '0;
      hi_sel_q <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      mcand_q  <= mcand_d;
      cnt_q    <= cnt_d;
      hi_sel_q <= hi_sel_d;
      result_q <= result_d;
    end
  end

  // The ALU sum is only WIDTH bits wide; an unsigned wrap below acc_hi means
  // the addition carried out, which becomes the new top bit after the shift.
  always_comb begin
    carry   = (alu_out < acc_hi_q);
    next_hi = {carry, alu_out[WIDTH-1:1]};
    next_lo = {alu_out[0], acc_lo_q[WIDTH-1:1]};
  end

  always_comb begin
    state_d  = state_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    mcand_d  = mcand_q;
    cnt_d    = cnt_q;
    hi_sel_d = hi_sel_q;
    result_d = result_q;
    alu_ctr  = ALU_AND;
    alu_a    = '0;
    alu_b    = '0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          mcand_d  = op_a;
          acc_lo_d = op_b;
          acc_hi_d = '0;
          cnt_d    = '0;
          hi_sel_d = hi_sel;
          state_d  = S_RUN;
        end
      end

      S_RUN: begin
        alu_ctr  = ALU_ADD;
        alu_a    = acc_hi_q;
        alu_b    = acc_lo_q[0] ? mcand_q : '0;
        acc_hi_d = next_hi;
        acc_lo_d = next_lo;
        if (cnt_q == LAST_CNT) begin
          // Capture the selected word on the final iteration so it is
          // already registered during the single DONE cycle.
          result_d = hi_sel_q ? next_hi : next_lo;
          state_d  = S_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy   = (state_q != S_IDLE);
  assign done   = (state_q == S_DONE);
  assign result = result_q;

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Directed and randomised checks of the ALU-driven multiply sequencer, with a
// behavioural ALU on the return path.
module tb_alu_mul_sequencer;

  localparam int unsigned W = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [W-1:0]  op_a;
  logic [W-1:0]  op_b;
  logic          hi_sel;
  logic          busy;
  logic          done;
  logic [W-1:0]  result;
  logic [3:0]    alu_ctr;
  logic [W-1:0]  alu_a;
  logic [W-1:0]  alu_b;
  logic [W-1:0]  alu_out;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign alu_out = (alu_ctr == 4'd2) ? (alu_a + alu_b) : (alu_a & alu_b);

  alu_mul_sequencer #(
    .WIDTH  (W),
    .CTR_W  (4),
    .ALU_ADD(4'd2),
    .ALU_AND(4'd0)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op_a   (op_a),
    .op_b   (op_b),
    .hi_sel (hi_sel),
    .busy   (busy),
    .done   (done),
    .result (result),
    .alu_ctr(alu_ctr),
    .alu_a  (alu_a),
    .alu_b  (alu_b),
    .alu_out(alu_out)
  );

  // Drives one operation; lat counts sampled cycles from the one after the
  // accepting edge up to and including the done cycle.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic hs,
                        output logic [W-1:0] res, output int lat, output int busy_n,
                        output logic seen);
    int guard;
    guard = 0;
    @(negedge clk);
    while (busy && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    op_a = a; op_b = b; hi_sel = hs; start = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
    lat    = 1;
    busy_n = busy ? 1 : 0;
    while (!done && lat < 100) begin
      @(posedge clk); #1;
      lat++;
      if (busy) busy_n++;
    end
    seen = done;
    res  = result;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; op_a = '0; op_b = '0; hi_sel = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++;
    if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
    n_checks++;
    if (result !== '0) begin n_fail++; $display("FAIL reset_result: got %h want 0", result); end
    n_checks++;
    if (alu_ctr !== 4'd0) begin n_fail++; $display("FAIL reset_alu_ctr: got %h want 0", alu_ctr); end
    n_checks++;
    if (alu_a !== '0 || alu_b !== '0) begin
      n_fail++; $display("FAIL reset_alu_ops: got a=%h b=%h want 0/0", alu_a, alu_b);
    end
  endtask

  task automatic test_basic;
    logic [W-1:0] r; int lat; int bn; logic seen;
    run_op(32'd3, 32'd5, 1'b0, r, lat, bn, seen);
    n_checks++;
    if (seen !== 1'b1 || lat != 33) begin
      n_fail++; $display("FAIL basic_latency: got done=%b lat=%0d want done=1 lat=33", seen, lat);
    end
    n_checks++;
    if (r !== 32'd15) begin n_fail++; $display("FAIL basic_result: got %0d want 15", r); end
    n_checks++;
    if (bn != 33) begin n_fail++; $display("FAIL basic_busy_cycles: got %0d want 33", bn); end
    n_checks++;
    if (alu_ctr !== 4'd0 || alu_a !== '0 || alu_b !== '0) begin
      n_fail++; $display("FAIL done_alu_idle: got ctr=%h a=%h b=%h want 0/0/0", alu_ctr, alu_a, alu_b);
    end
    @(posedge clk); #1;
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL done_pulse_width: got done=%b busy=%b want 0/0", done, busy);
    end
    n_checks++;
    if (result !== 32'd15) begin n_fail++; $display("FAIL result_hold: got %0d want 15", result); end
  endtask

  task automatic test_alu_ports;
    int guard;
    @(negedge clk);
    op_a = 32'd3; op_b = 32'd5; hi_sel = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n_checks++;
    if (alu_ctr !== 4'd2 || alu_a !== 32'd0 || alu_b !== 32'd3) begin
      n_fail++; $display("FAIL run_alu_iter0: got ctr=%h a=%h b=%h want 2/0/3", alu_ctr, alu_a, alu_b);
    end
    @(posedge clk); #1;
    // after iter0: acc_hi = 3>>1 = 1, acc_lo bit0 = 0 (5>>1 = 2, with alu_out[0]=1 shifted in top)
    n_checks++;
    if (alu_ctr !== 4'd2 || alu_a !== 32'd1 || alu_b !== 32'd0) begin
      n_fail++; $display("FAIL run_alu_iter1: got ctr=%h a=%h b=%h want 2/1/0", alu_ctr, alu_a, alu_b);
    end
    guard = 0;
    while (busy && guard < 100) begin @(posedge clk); #1; guard++; end
  endtask

  task automatic test_carry;
    logic [W-1:0] r; int lat; int bn; logic seen;
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, r, lat, bn, seen);
    n_checks++;
    if (!seen || r !== 32'hFFFF_FFFE) begin
      n_fail++; $display("FAIL carry_hi: got done=%b %h want FFFFFFFE", seen, r);
    end
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, r, lat, bn, seen);
    n_checks++;
    if (!seen || r !== 32'h0000_0001) begin
      n_fail++; $display("FAIL carry_lo: got done=%b %h want 00000001", seen, r);
    end
  endtask

  task automatic test_zero_and_msb;
    logic [W-1:0] r; int lat; int bn; logic seen;
    run_op(32'd0, 32'h1234_5678, 1'b0, r, lat, bn, seen);
    n_checks++;
    if (!seen || r !== 32'd0 || lat != 33) begin
      n_fail++; $display("FAIL zero_operand: got done=%b r=%h lat=%0d want 1/0/33", seen, r, lat);
    end
    run_op(32'h8000_0000, 32'd2, 1'b1, r, lat, bn, seen);
    n_checks++;
    if (!seen || r !== 32'd1) begin
      n_fail++; $display("FAIL msb_hi: got done=%b %h want 1", seen, r);
    end
  endtask

  task automatic test_back_to_back;
    int cyc; int first_t; int second_t; int n_done;
    logic [W-1:0] r1; logic [W-1:0] r2;
    int guard;
    guard = 0;
    @(negedge clk);
    while (busy && guard < 100) begin @(negedge clk); guard++; end
    op_a = 32'd7; op_b = 32'd9; hi_sel = 1'b0; start = 1'b1;
    cyc = 0; first_t = -1; second_t = -1; n_done = 0; r1 = '0; r2 = '0;
    while (cyc < 120) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == 10) begin op_a = 32'd11; op_b = 32'd13; end
      if (done) begin
        n_done++;
        if (first_t < 0) begin first_t = cyc; r1 = result; end
        else if (second_t < 0) begin second_t = cyc; r2 = result; end
      end
    end
    start = 1'b0;
    n_checks++;
    if (first_t != 33 || r1 !== 32'd63) begin
      n_fail++; $display("FAIL b2b_first: got t=%0d r=%0d want t=33 r=63", first_t, r1);
    end
    n_checks++;
    if (second_t - first_t != 34 || r2 !== 32'd143) begin
      n_fail++; $display("FAIL b2b_second: got gap=%0d r=%0d want gap=34 r=143", second_t - first_t, r2);
    end
    n_checks++;
    if (n_done != 3) begin n_fail++; $display("FAIL b2b_done_count: got %0d want 3", n_done); end
    guard = 0;
    while (busy && guard < 100) begin @(posedge clk); #1; guard++; end
  endtask

  task automatic test_abort;
    logic [W-1:0] r; int lat; int bn; logic seen; int n_done;
    @(negedge clk);
    op_a = 32'd1000; op_b = 32'd1000; hi_sel = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL abort_state: got busy=%b done=%b want 0/0", busy, done);
    end
    n_checks++;
    if (result !== '0) begin n_fail++; $display("FAIL abort_result: got %h want 0", result); end
    n_done = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) n_done++;
    end
    n_checks++;
    if (n_done != 0) begin n_fail++; $display("FAIL abort_no_done: got %0d pulses want 0", n_done); end
    run_op(32'd6, 32'd7, 1'b0, r, lat, bn, seen);
    n_checks++;
    if (!seen || r !== 32'd42 || lat != 33) begin
      n_fail++; $display("FAIL abort_recover: got done=%b r=%0d lat=%0d want 1/42/33", seen, r, lat);
    end
  endtask

  task automatic test_random;
    logic [W-1:0] a; logic [W-1:0] b; logic [2*W-1:0] p;
    logic [W-1:0] exp_r; logic [W-1:0] r; int lat; int bn; logic seen; logic hs;
    for (int i = 0; i < 1000; i++) begin
      a  = $urandom;
      b  = $urandom;
      hs = (i % 2) == 1;
      p  = {{W{1'b0}}, a} * {{W{1'b0}}, b};
      exp_r = hs ? p[2*W-1:W] : p[W-1:0];
      run_op(a, b, hs, r, lat, bn, seen);
      n_checks++;
      if (!seen || r !== exp_r) begin
        n_fail++;
        $display("FAIL random_%0d: a=%h b=%h hi=%b got done=%b r=%h want %h", i, a, b, hs, seen, r, exp_r);
      end
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_alu_ports;
    test_carry;
    test_zero_and_msb;
    test_back_to_back;
    test_abort;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
